// File: rtl/button_toggle_conditioner.sv
// button_toggle_conditioner
//
// Conditions a raw, bouncy push-button into a single-cycle toggle pulse for a
// downstream T flip-flop. The raw level first passes through a synchroniser.
// A four-state debounce FSM (IDLE / PRESS_WAIT / HELD / RELEASE_WAIT) then
// requires DEBOUNCE_CYCLES consecutive equal samples before it accepts a
// press or a release.
//
// Outputs are the toggle pulse, the debounced level, a busy flag and a
// wrapping 8-bit press counter. All outputs are registered.
//
// Optional feature: define BUTTON_TOGGLE_AUTOREPEAT_EN to add an auto-repeat
// timer. While the button stays in HELD, the timer emits extra pulses:
//   - the first one REPEAT_DELAY cycles after the entry pulse;
//   - then one every REPEAT_PERIOD cycles.
// Without the macro the timer is absent and the REPEAT_* parameters are
// ignored.

module button_toggle_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int REPEAT_DELAY    = 50000,
  parameter int REPEAT_PERIOD   = 10000
) (
  input  logic       input_clock,
  input  logic       input_reset,
  input  logic       input_button,
  input  logic       input_enable,
  output logic       output_t,
  output logic       output_level,
  output logic       output_busy,
  output logic [7:0] output_press_count
);

  // Debounce counter sizing and the constants it is compared against.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;

  // Shift the raw button level through the synchroniser chain.
  always_ff @(posedge input_clock or posedge input_reset) begin
    if (input_reset) begin
      sync_q <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], input_button};
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Debounce FSM
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept_s;

  // Hold the FSM state and its debounce counter.
  always_ff @(posedge input_clock or posedge input_reset) begin
    if (input_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and counter. accept_s marks the edge on which a press is accepted.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sync_s) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end
      end
      ST_PRESS_WAIT: begin
        if (!sync_s) begin
          // Bounce: abandon the press without a pulse.
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = ST_HELD;
          cnt_d    = CNT_ZERO;
          accept_s = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HELD: begin
        if (!sync_s) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = ST_HELD;
          cnt_d   = CNT_ZERO;
        end
      end
      ST_RELEASE_WAIT: begin
        if (sync_s) begin
          // Release glitch: return to HELD without a pulse.
          state_d = ST_HELD;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Auto-repeat timer (optional)
  // ---------------------------------------------------------------------------
  logic repeat_s;

`ifdef BUTTON_TOGGLE_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
  localparam logic [REP_W-1:0] REP_ZERO        = {REP_W{1'b0}};
  localparam logic [REP_W-1:0] REP_ONE         = REP_W'(1);
  localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_armed_q, rep_armed_d;

  // Hold the repeat timer and the flag that says the first repeat has fired.
  always_ff @(posedge input_clock or posedge input_reset) begin
    if (input_reset) begin
      rep_cnt_q   <= REP_ZERO;
      rep_armed_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_armed_q <= rep_armed_d;
    end
  end

  // Advance the timer while HELD persists; any exit from HELD clears it.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_armed_d = rep_armed_q;
    repeat_s    = 1'b0;
    if ((state_q == ST_HELD) && (state_d == ST_HELD)) begin
      if (rep_cnt_q == (rep_armed_q ? REP_PERIOD_LAST : REP_DELAY_LAST)) begin
        repeat_s    = 1'b1;
        rep_cnt_d   = REP_ZERO;
        rep_armed_d = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + REP_ONE;
      end
    end else begin
      rep_cnt_d   = REP_ZERO;
      rep_armed_d = 1'b0;
    end
  end
`else
  assign repeat_s = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  logic       t_q, t_d;
  logic       level_q, level_d;
  logic       busy_q, busy_d;
  logic [7:0] count_q, count_d;

  // Next output values, derived from the next FSM state. A pulse is dropped
  // when enable is low, and also when it would follow another pulse directly.
  always_comb begin
    t_d     = 1'b0;
    level_d = 1'b0;
    busy_d  = 1'b0;
    count_d = count_q;
    if ((accept_s || repeat_s) && input_enable && !t_q) begin
      t_d     = 1'b1;
      count_d = count_q + 8'd1;
    end else begin
      t_d     = 1'b0;
      count_d = count_q;
    end
    if ((state_d == ST_HELD) || (state_d == ST_RELEASE_WAIT)) begin
      level_d = 1'b1;
    end else begin
      level_d = 1'b0;
    end
    if ((state_d == ST_PRESS_WAIT) || (state_d == ST_RELEASE_WAIT)) begin
      busy_d = 1'b1;
    end else begin
      busy_d = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge input_clock or posedge input_reset) begin
    if (input_reset) begin
      t_q     <= 1'b0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
      count_q <= 8'd0;
    end else begin
      t_q     <= t_d;
      level_q <= level_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign output_t           = t_q;
  assign output_level       = level_q;
  assign output_busy        = busy_q;
  assign output_press_count = count_q;

endmodule

// File: tb/tb_button_toggle_conditioner.sv
// Testbench for button_toggle_conditioner (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// The reference model describes debouncing as a run of synchronised samples
// that disagree with the accepted level. It flips the level once that run
// reaches DEBOUNCE_CYCLES samples. Directed checks pin the model to the
// hand-computed timings.

module tb_button_toggle_conditioner;

  localparam int SYNC    = 2;
  localparam int DEB     = 4;
  localparam int RDELAY  = 8;
  localparam int RPERIOD = 3;
`ifdef BUTTON_TOGGLE_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic       en;
  logic       t;
  logic       level;
  logic       busy;
  logic [7:0] cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  button_toggle_conditioner #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RDELAY),
    .REPEAT_PERIOD  (RPERIOD)
  ) dut (
    .input_clock       (clk),
    .input_reset       (rst),
    .input_button      (btn),
    .input_enable      (en),
    .output_t          (t),
    .output_level      (level),
    .output_busy       (busy),
    .output_press_count(cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Set the button, advance n falling edges, return 1 time unit after the last.
  task automatic go(input logic b, input int n);
    btn = b;
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Reference model plus per-cycle compare.
  bit mq[$];
  bit m_level, m_t, m_prev_held, m_s, m_acc, m_fire, m_held;
  int m_run, m_cnt, m_age;

  initial begin : model_cmp
    forever begin
      @(negedge clk);
      if (rst) begin
        mq = {};
        repeat (SYNC) mq.push_back(1'b0);
        m_level = 1'b0; m_run = 0; m_cnt = 0; m_t = 1'b0;
        m_age = 0; m_prev_held = 1'b0;
      end else begin
        m_s = mq.pop_front();
        mq.push_back(btn);
        m_acc  = 1'b0;
        m_fire = 1'b0;
        if (m_s != m_level) begin
          m_run++;
          if (m_run == DEB) begin
            m_level = m_s;
            m_run   = 0;
            m_acc   = m_s;
          end
        end else begin
          m_run = 0;
        end
        m_held = m_level && (m_run == 0);
        if (m_held && m_prev_held) begin
          m_age++;
          if (AR && (m_age == RDELAY || (m_age > RDELAY && (m_age - RDELAY) % RPERIOD == 0)))
            m_fire = 1'b1;
        end else begin
          m_age = 0;
        end
        m_prev_held = m_held;
        m_t = (m_acc || m_fire) && en && !m_t;
        if (m_t) m_cnt = (m_cnt + 1) % 256;
      end
      chk("cyc_t", {31'd0, t}, {31'd0, m_t});
      chk("cyc_level", {31'd0, level}, {31'd0, m_level});
      chk("cyc_busy", {31'd0, busy}, {31'd0, (m_run > 0)});
      chk("cyc_count", {24'd0, cnt}, m_cnt);
    end
  end

  initial begin : stim
    rst = 1'b1; btn = 1'b0; en = 1'b1;
    go(1'b0, 3);
    chk("reset_t", {31'd0, t}, 32'd0);
    chk("reset_level", {31'd0, level}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_count", {24'd0, cnt}, 32'd0);
    rst = 1'b0;
    go(1'b0, 4);

    // Clean press: pulse in the cycle after edge 5.
    go(1'b1, 5);
    chk("clean_t_early", {31'd0, t}, 32'd0);
    chk("clean_busy", {31'd0, busy}, 32'd1);
    go(1'b1, 1);
    chk("clean_t", {31'd0, t}, 32'd1);
    chk("clean_level", {31'd0, level}, 32'd1);
    chk("clean_count", {24'd0, cnt}, 32'd1);
    go(1'b1, 1);
    chk("clean_t_single", {31'd0, t}, 32'd0);
    go(1'b0, 10);
    chk("release_level", {31'd0, level}, 32'd0);

    // Bounce 1,0,1,0 then stable 1.
    go(1'b1, 1); go(1'b0, 1); go(1'b1, 1); go(1'b0, 1);
    go(1'b1, 5);
    chk("bounce_t_early", {31'd0, t}, 32'd0);
    go(1'b1, 1);
    chk("bounce_t", {31'd0, t}, 32'd1);
    chk("bounce_count", {24'd0, cnt}, 32'd2);

    // Two-cycle release glitch while HELD.
    go(1'b1, 3);
    go(1'b0, 2);
    go(1'b1, 6);
    chk("glitch_level", {31'd0, level}, 32'd1);
    chk("glitch_busy", {31'd0, busy}, 32'd0);
    chk("glitch_count", {24'd0, cnt}, 32'd2);
    go(1'b0, 10);

    // Press while disabled.
    en = 1'b0;
    go(1'b1, 6);
    chk("gated_t", {31'd0, t}, 32'd0);
    chk("gated_level", {31'd0, level}, 32'd1);
    go(1'b1, 2);
    chk("gated_count", {24'd0, cnt}, 32'd2);
    go(1'b0, 10);
    en = 1'b1;

    // Counter wrap after 256 presses from zero.
    rst = 1'b1;
    go(1'b0, 2);
    rst = 1'b0;
    go(1'b0, 3);
    for (int i = 0; i < 256; i++) begin
      go(1'b1, 7);
      go(1'b0, 7);
      if (i == 254) chk("count_255", {24'd0, cnt}, 32'd255);
    end
    chk("count_wrap", {24'd0, cnt}, 32'd0);

    // Reset while held, then re-debounce.
    go(1'b1, 7);
    chk("prereset_count", {24'd0, cnt}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midreset_level", {31'd0, level}, 32'd0);
    chk("midreset_count", {24'd0, cnt}, 32'd0);
    chk("midreset_t", {31'd0, t}, 32'd0);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    go(1'b1, 3);
    rst = 1'b0;
    go(1'b1, 5);
    chk("postreset_t_early", {31'd0, t}, 32'd0);
    go(1'b1, 1);
    chk("postreset_t", {31'd0, t}, 32'd1);
    chk("postreset_count", {24'd0, cnt}, 32'd1);
    go(1'b0, 10);

`ifdef BUTTON_TOGGLE_AUTOREPEAT_EN
    // Auto-repeat: pulses at +0, +8, +11, +14, +17.
    go(1'b1, 6);
    chk("ar_p0", {31'd0, t}, 32'd1);
    go(1'b1, 8);
    chk("ar_p8", {31'd0, t}, 32'd1);
    go(1'b1, 3);
    chk("ar_p11", {31'd0, t}, 32'd1);
    go(1'b1, 3);
    chk("ar_p14", {31'd0, t}, 32'd1);
    go(1'b1, 3);
    chk("ar_p17", {31'd0, t}, 32'd1);
    go(1'b0, 10);
    chk("ar_count", {24'd0, cnt}, 32'd6);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/button_toggle_conditioner.md
# button_toggle_conditioner

Upstream conditioner for the T flip-flop stage. It takes a raw, bouncy push-button level and synchronises and debounces it. It then emits a single-cycle toggle pulse per accepted press, which drives the T input of the downstream flip-flop. It also exports the debounced level and a wrapping press counter for LED/debug display.

## Interface
Parameters:
- SYNC_STAGES, 2: synchroniser depth on the raw button input, minimum 2.
- DEBOUNCE_CYCLES, 1000: number of consecutive equal synchronised samples required to accept a press or release, minimum 2.
- REPEAT_DELAY, 50000: cycles in HELD before the first auto-repeat pulse. Used only with auto-repeat.
- REPEAT_PERIOD, 10000: cycles between subsequent auto-repeat pulses. Used only with auto-repeat.

Ports:
- input_clock, in, 1: single clock; all state updates on its rising edge.
- input_reset, in, 1: asynchronous, active-high reset.
- input_button, in, 1: raw push-button level, asynchronous to input_clock; 1 = pressed.
- input_enable, in, 1: when 0, pulse generation and counting are suppressed, but the state is still tracked.
- output_t, out, 1: one-cycle toggle pulse to the T flip-flop T input.
- output_level, out, 1: debounced button level; 1 while the FSM is in HELD or RELEASE_WAIT.
- output_busy, out, 1: 1 while the FSM is in PRESS_WAIT or RELEASE_WAIT.
- output_press_count, out, 8: count of accepted presses (including repeats); wraps.

## Operation
- Synchroniser: a chain of SYNC_STAGES flops; the last stage is s. All flops clear to 0 on reset.
- Debounce counter cnt: width is clog2(DEBOUNCE_CYCLES+1), unsigned.
- FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT. Reset state is IDLE.
- IDLE:
  - s=1 → PRESS_WAIT, cnt=1.
  - s=0 → stay in IDLE.
- PRESS_WAIT:
  - s=0 → IDLE, cnt=0, no pulse.
  - s=1 and cnt<DEBOUNCE_CYCLES-1 → cnt+1.
  - s=1 and cnt=DEBOUNCE_CYCLES-1 → HELD, cnt=0. Assert output_t for one cycle and increment output_press_count, both gated by input_enable.
- HELD:
  - s=0 → RELEASE_WAIT, cnt=1.
  - s=1 → stay in HELD (auto-repeat timer runs when compiled in).
- RELEASE_WAIT:
  - s=1 → HELD, cnt=0, no pulse.
  - s=0 and cnt=DEBOUNCE_CYCLES-1 → IDLE.
  - Otherwise cnt+1.
- output_t, output_level, output_busy and output_press_count are all registered outputs.
- Pulse rules:
  - output_t is never high on two consecutive cycles.
  - output_t is 0 whenever input_enable=0 on the accepting edge; a suppressed pulse is not deferred.
- output_press_count wraps from 255 to 0 with no flag.
- Reset mid-operation: every register clears immediately, including the synchroniser. If the button is still held when reset releases, it is debounced as a new press.
- Reset values: output_t=0, output_level=0, output_busy=0, output_press_count=0.

## Timing
- Press latency, measured from the first clock edge that samples input_button=1 (stable) to output_t high: SYNC_STAGES+DEBOUNCE_CYCLES-1 edges. output_t is visible in the following cycle.
- output_level rises in the same cycle that output_t pulses. Its fall latency mirrors the press latency.
- Glitch rejection: any low (or high) run of s shorter than DEBOUNCE_CYCLES samples causes no state change in HELD (or IDLE).
- input_enable is sampled on the accepting edge only; there is no handshake.

## Configuration
- Macro: BUTTON_TOGGLE_AUTOREPEAT_EN.
- Defined:
  - A repeat timer runs in HELD.
  - The first extra pulse fires REPEAT_DELAY cycles after the HELD entry pulse, then every REPEAT_PERIOD cycles while the FSM remains in HELD.
  - Each repeat pulse increments output_press_count; all pulses are subject to input_enable.
  - The timer clears on leaving HELD, including a transition to RELEASE_WAIT.
- Undefined:
  - The timer logic is absent and REPEAT_* parameters are ignored.
  - Exactly one pulse is produced per accepted press.

## Test plan
All cases use SYNC_STAGES=2 and DEBOUNCE_CYCLES=4.
- Clean press: input_button held 1 from edge 0 → output_t high for exactly the cycle after edge 5; output_level=1 from the same cycle; output_press_count=1.
- Bounce: input_button pattern 1,0,1,0 then stable 1 → a single output_t pulse, 5 edges after the stable-1 start; output_press_count=1.
- Release glitch in HELD: a 2-cycle low on input_button → output_level stays 1, no output_t pulse, FSM returns to HELD.
- Enable gating: press with input_enable=0 → output_t stays 0, output_press_count unchanged, output_level=1.
- Wrap and reset: 256 presses → output_press_count=0. Then assert input_reset while the button is held → all outputs 0 immediately; after reset release, a new pulse arrives 5 edges later.
- With BUTTON_TOGGLE_AUTOREPEAT_EN defined, REPEAT_DELAY=8 and REPEAT_PERIOD=3, button held for 20 cycles after acceptance → pulses at +0, +8, +11, +14, +17 cycles; output_press_count=5.
